// File: rtl/card_pkg.sv
// card_pkg: shared card type, card code constants and baccarat point value helper
package card_pkg;
  typedef logic [3:0] card_t;
  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE = 4'd1;
  localparam card_t CARD_KING = 4'd13;
  localparam int SCORE_BASE = 10;
  function automatic logic [3:0] card_value(card_t c);
    return c > 4'd9 ? 4'd0 : c;
  endfunction
endpackage

// File: rtl/hand_scorer.sv
// hand_scorer: combinational baccarat score of a three-card hand
module hand_scorer
  import card_pkg::*;
#(
  parameter int SCORE_MOD = SCORE_BASE
) (
  input  card_t       c1,
  input  card_t       c2,
  input  card_t       c3,
  output logic [3:0]  score
);
  logic [4:0] sum;
  always_comb begin
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    score = 4'(sum >= 5'(2 * SCORE_MOD) ? sum - 5'(2 * SCORE_MOD) :
               sum >= 5'(SCORE_MOD) ? sum - 5'(SCORE_MOD) : sum);
  end
endmodule

// File: rtl/card_datapath.sv
// card_datapath: deals a card per rising load strobe, holds the six card regs and scores both hands
module card_datapath
  import card_pkg::*;
#(
  parameter card_t CARD_MIN = CARD_ACE,
  parameter card_t CARD_MAX = CARD_KING,
  parameter int SCORE_MOD = SCORE_BASE
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       clear_hand,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       inject_en,
  input  logic [3:0] inject_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] deal_count,
  output logic       load_err
);
  card_t cards [6];
  card_t cnt, raw, nxt;
  logic [5:0] ld, prev, ev;
  logic multi, bad, occ;
  assign ld = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  always_comb begin
    ev = ld & ~prev;
    multi = (ev & (ev - 6'd1)) != 6'd0;
    raw = inject_en ? inject_card : cnt;
    bad = raw == CARD_EMPTY || raw > CARD_MAX;
    nxt = bad ? CARD_EMPTY : raw;
    occ = 1'b0;
    for (int i = 0; i < 6; i++) occ = occ | (ev[i] & (cards[i] != CARD_EMPTY));
  end
  // clear_hand dominates loads but leaves the sticky error untouched
  always_ff @(posedge slow_clock or negedge resetb)
    if (!resetb) begin
      cnt <= CARD_MIN;
      prev <= '0;
      deal_count <= '0;
      load_err <= 1'b0;
      for (int i = 0; i < 6; i++) cards[i] <= CARD_EMPTY;
    end else begin
      cnt <= cnt == CARD_MAX ? CARD_MIN : cnt + 4'd1;
      prev <= ld;
      if (clear_hand) begin
        deal_count <= '0;
        for (int i = 0; i < 6; i++) cards[i] <= CARD_EMPTY;
      end else if (multi) load_err <= 1'b1;
      else if (|ev) begin
        for (int i = 0; i < 6; i++) if (ev[i]) cards[i] <= nxt;
        if (occ || bad) load_err <= 1'b1;
        if (!occ && deal_count != 3'd6) deal_count <= deal_count + 3'd1;
      end
    end
  assign {pcard1, pcard2, pcard3} = {cards[0], cards[1], cards[2]};
  assign {dcard1, dcard2, dcard3} = {cards[3], cards[4], cards[5]};
  hand_scorer #(.SCORE_MOD(SCORE_MOD)) u_player (.c1(cards[0]), .c2(cards[1]), .c3(cards[2]), .score(pscore));
  hand_scorer #(.SCORE_MOD(SCORE_MOD)) u_dealer (.c1(cards[3]), .c2(cards[4]), .c3(cards[5]), .score(dscore));
endmodule
